// File: rtl/aemb_wbmux.sv
// aemb_wbmux: merges the AEMB instruction (iwb) and data (dwb) Wishbone ports onto
// one external master port (xwb), with fixed data priority and a bus-timeout watchdog.
module aemb_wbmux #(
  parameter int AW   = 32,
  parameter int TOUT = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-3:0] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-3:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          xwb_cyc_o,
  output logic          xwb_stb_o,
  output logic          xwb_we_o,
  output logic [3:0]    xwb_sel_o,
  output logic [AW-3:0] xwb_adr_o,
  output logic [31:0]   xwb_dat_o,
  input  logic [31:0]   xwb_dat_i,
  input  logic          xwb_ack_i,
  output logic          bus_err_o,
  output logic [1:0]    fsm_state_o
);

  // Handshake: a core port raises stb_i and holds it, with its request fields stable,
  // until it sees its ack_o; ack_o is a one-cycle registered pulse and dat_o is valid
  // in that cycle. On xwb, stb/cyc stay high with fields constant until xwb_ack_i.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IGNT = 2'd1,
    ST_DGNT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [7:0] TLIM = 8'(TOUT - 1);

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic          xstb_q;
  logic          xwe_q;
  logic [3:0]    xsel_q;
  logic [AW-3:0] xadr_q;
  logic [31:0]   xdat_q;
  logic [31:0]   idat_q;
  logic [31:0]   ddat_q;
  logic          iack_q;
  logic          dack_q;
  logic          err_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      xstb_q  <= 1'b0;
      xwe_q   <= 1'b0;
      xsel_q  <= 4'h0;
      xadr_q  <= '0;
      xdat_q  <= 32'h0;
      idat_q  <= 32'h0;
      ddat_q  <= 32'h0;
      iack_q  <= 1'b0;
      dack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      iack_q <= 1'b0;
      dack_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 8'd0;
          if (dwb_stb_i) begin
            state_q <= ST_DGNT;
            xstb_q  <= 1'b1;
            xwe_q   <= dwb_wre_i;
            xsel_q  <= dwb_sel_i;
            xadr_q  <= dwb_adr_i;
            xdat_q  <= dwb_dat_i;
          end else if (iwb_stb_i) begin
            state_q <= ST_IGNT;
            xstb_q  <= 1'b1;
            xwe_q   <= 1'b0;
            xsel_q  <= 4'hF;
            xadr_q  <= iwb_adr_i;
            xdat_q  <= 32'h0;
          end
        end
        ST_IGNT, ST_DGNT: begin
          // A slave ack in the expiry cycle takes precedence over the watchdog.
          if (xwb_ack_i || (cnt_q == TLIM)) begin
            state_q <= ST_ACK;
            xstb_q  <= 1'b0;
            xwe_q   <= 1'b0;
            xsel_q  <= 4'h0;
            xadr_q  <= '0;
            xdat_q  <= 32'h0;
            err_q   <= ~xwb_ack_i;
            if (state_q == ST_DGNT) begin
              dack_q <= 1'b1;
              ddat_q <= xwb_ack_i ? xwb_dat_i : 32'h0;
            end else begin
              iack_q <= 1'b1;
              idat_q <= xwb_ack_i ? xwb_dat_i : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign iwb_dat_o   = idat_q;
  assign iwb_ack_o   = iack_q;
  assign dwb_dat_o   = ddat_q;
  assign dwb_ack_o   = dack_q;
  assign xwb_cyc_o   = xstb_q;
  assign xwb_stb_o   = xstb_q;
  assign xwb_we_o    = xwe_q;
  assign xwb_sel_o   = xsel_q;
  assign xwb_adr_o   = xadr_q;
  assign xwb_dat_o   = xdat_q;
  assign bus_err_o   = err_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_aemb_wbmux.sv
// Bench for aemb_wbmux: directed scenarios plus randomized transfers checked against a
// cycle-count and data model derived from the wait-state / watchdog rules.
module tb_aemb_wbmux;
  localparam int AW   = 32;
  localparam int TOUT = 4;
  localparam logic [1:0] IDLE_ENC = 2'd0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iwb_stb_i = 1'b0;
  logic [AW-3:0] iwb_adr_i = '0;
  logic [31:0]   iwb_dat_o;
  logic          iwb_ack_o;
  logic          dwb_stb_i = 1'b0;
  logic          dwb_wre_i = 1'b0;
  logic [3:0]    dwb_sel_i = 4'h0;
  logic [AW-3:0] dwb_adr_i = '0;
  logic [31:0]   dwb_dat_i = 32'h0;
  logic [31:0]   dwb_dat_o;
  logic          dwb_ack_o;
  logic          xwb_cyc_o, xwb_stb_o, xwb_we_o;
  logic [3:0]    xwb_sel_o;
  logic [AW-3:0] xwb_adr_o;
  logic [31:0]   xwb_dat_o;
  logic [31:0]   xwb_dat_i = 32'h0;
  logic          xwb_ack_i = 1'b0;
  logic          bus_err_o;
  logic [1:0]    fsm_state_o;

  int tests_run = 0;
  int tests_failed = 0;

  // slave model configuration
  int          slv_wait = 0;
  logic [31:0] slv_data = 32'h0;
  bit          slv_stray = 1'b0;
  int          slv_cnt = 0;

  // expected dat_o values of each port and queue of expected completion data
  logic [31:0] model_idat = 32'h0;
  logic [31:0] model_ddat = 32'h0;
  logic [31:0] exp_q[$];

  // observations filled by run_xfer
  int            obs_ack_cyc, obs_stb_first, obs_stb_last, obs_stb_cnt;
  int            obs_bad_ack, obs_err_extra, obs_cyc_mismatch;
  bit            obs_stable;
  logic [31:0]   obs_rd;
  logic          obs_err, obs_we;
  logic [3:0]    obs_sel;
  logic [AW-3:0] obs_adr;
  logic [31:0]   obs_wdat;

  aemb_wbmux #(.AW(AW), .TOUT(TOUT)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_stb_i(dwb_stb_i), .dwb_wre_i(dwb_wre_i), .dwb_sel_i(dwb_sel_i), .dwb_adr_i(dwb_adr_i),
    .dwb_dat_i(dwb_dat_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
    .xwb_cyc_o(xwb_cyc_o), .xwb_stb_o(xwb_stb_o), .xwb_we_o(xwb_we_o), .xwb_sel_o(xwb_sel_o),
    .xwb_adr_o(xwb_adr_o), .xwb_dat_o(xwb_dat_o), .xwb_dat_i(xwb_dat_i), .xwb_ack_i(xwb_ack_i),
    .bus_err_o(bus_err_o), .fsm_state_o(fsm_state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  // Slave: acks after slv_wait cycles of xwb_stb_o; random data on non-ack cycles.
  always begin
    @(posedge clk); #1;
    if (xwb_stb_o === 1'b1) begin
      xwb_ack_i = (slv_cnt == slv_wait);
      xwb_dat_i = (slv_cnt == slv_wait) ? slv_data : $urandom;
      slv_cnt++;
    end else begin
      xwb_ack_i = slv_stray;
      xwb_dat_i = $urandom;
      slv_cnt = 0;
    end
  end

  function automatic bit outs_zero();
    return iwb_ack_o === 1'b0 && dwb_ack_o === 1'b0 && bus_err_o === 1'b0 &&
           xwb_cyc_o === 1'b0 && xwb_stb_o === 1'b0 && xwb_we_o === 1'b0 &&
           xwb_sel_o === 4'h0 && xwb_adr_o === '0 && xwb_dat_o === 32'h0 &&
           iwb_dat_o === 32'h0 && dwb_dat_o === 32'h0;
  endfunction

  // Driver: issues one request in the current cycle (cycle 0) and observes until its ack.
  task automatic run_xfer(input bit is_d, input logic we, input logic [3:0] sel,
                          input logic [AW-3:0] adr, input logic [31:0] wdat);
    obs_ack_cyc = -1; obs_stb_first = -1; obs_stb_last = -1; obs_stb_cnt = 0;
    obs_bad_ack = 0; obs_err_extra = 0; obs_cyc_mismatch = 0; obs_stable = 1'b1;
    obs_rd = 32'h0; obs_err = 1'b0;
    obs_we = 1'b0; obs_sel = 4'h0; obs_adr = '0; obs_wdat = 32'h0;
    if (is_d) begin
      dwb_stb_i = 1'b1; dwb_wre_i = we; dwb_sel_i = sel; dwb_adr_i = adr; dwb_dat_i = wdat;
    end else begin
      iwb_stb_i = 1'b1; iwb_adr_i = adr;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (xwb_cyc_o !== xwb_stb_o) obs_cyc_mismatch++;
      if (xwb_stb_o === 1'b1) begin
        if (obs_stb_first < 0) begin
          obs_stb_first = k;
          obs_we = xwb_we_o; obs_sel = xwb_sel_o; obs_adr = xwb_adr_o; obs_wdat = xwb_dat_o;
        end else if ({xwb_we_o, xwb_sel_o, xwb_adr_o, xwb_dat_o} !== {obs_we, obs_sel, obs_adr, obs_wdat}) begin
          obs_stable = 1'b0;
        end
        obs_stb_last = k;
        obs_stb_cnt++;
      end
      if ((is_d ? iwb_ack_o : dwb_ack_o) !== 1'b0) obs_bad_ack++;
      if ((is_d ? dwb_ack_o : iwb_ack_o) === 1'b1) begin
        obs_ack_cyc = k;
        obs_rd = is_d ? dwb_dat_o : iwb_dat_o;
        obs_err = bus_err_o;
        break;
      end else if (bus_err_o !== 1'b0) begin
        obs_err_extra++;
      end
    end
    dwb_stb_i = 1'b0;
    iwb_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (!outs_zero() || fsm_state_o !== IDLE_ENC) begin
      tests_failed++;
      $display("FAIL reset_outputs state=%0d iack=%b dack=%b stb=%b", fsm_state_o, iwb_ack_o, dwb_ack_o, xwb_stb_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (!outs_zero()) begin
        tests_failed++;
        $display("FAIL idle_outputs cycle=%0d stb=%b sel=%h adr=%h idat=%h ddat=%h required all zero",
                 k, xwb_stb_o, xwb_sel_o, xwb_adr_o, iwb_dat_o, dwb_dat_o);
      end
    end
  endtask

  task automatic test_ifetch_zero_wait();
    slv_wait = 0; slv_data = 32'hB8000010;
    run_xfer(1'b0, 1'b0, 4'h0, 30'h100, 32'h0);
    model_idat = 32'hB8000010;
    tests_run++;
    if (obs_stb_first != 1 || obs_stb_cnt != 1) begin
      tests_failed++;
      $display("FAIL ifetch_stb first=%0d count=%0d required first=1 count=1", obs_stb_first, obs_stb_cnt);
    end
    tests_run++;
    if ({obs_we, obs_sel, obs_adr, obs_wdat} !== {1'b0, 4'hF, 30'h100, 32'h0}) begin
      tests_failed++;
      $display("FAIL ifetch_fields we=%b sel=%h adr=%h dat=%h required we=0 sel=f adr=100 dat=0", obs_we, obs_sel, obs_adr, obs_wdat);
    end
    tests_run++;
    if (obs_ack_cyc != 2 || obs_rd !== 32'hB8000010 || obs_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifetch_ack cycle=%0d data=%h err=%b required cycle=2 data=b8000010 err=0", obs_ack_cyc, obs_rd, obs_err);
    end
    @(posedge clk); #1;
    tests_run++;
    if (iwb_ack_o !== 1'b0 || xwb_stb_o !== 1'b0 || fsm_state_o !== IDLE_ENC || iwb_dat_o !== model_idat) begin
      tests_failed++;
      $display("FAIL ifetch_after ack=%b stb=%b state=%0d dat=%h required 0 0 0 %h", iwb_ack_o, xwb_stb_o, fsm_state_o, iwb_dat_o, model_idat);
    end
  endtask

  task automatic test_simultaneous();
    int d_ack, i_ack, i_stb, both;
    bit d_ok;
    logic [31:0] i_rd, d_rd;
    d_ack = -1; i_ack = -1; i_stb = -1; both = 0; d_ok = 1'b0; i_rd = 32'h0; d_rd = 32'h0;
    slv_wait = 0; slv_data = 32'h0BADF00D;
    dwb_stb_i = 1'b1; dwb_wre_i = 1'b1; dwb_sel_i = 4'b0011; dwb_adr_i = 30'h40; dwb_dat_i = 32'hDEADBEEF;
    iwb_stb_i = 1'b1; iwb_adr_i = 30'h200;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (dwb_ack_o === 1'b1 && iwb_ack_o === 1'b1) both++;
      if (k == 1)
        d_ok = (xwb_stb_o === 1'b1 && xwb_we_o === 1'b1 && xwb_sel_o === 4'b0011 &&
                xwb_adr_o === 30'h40 && xwb_dat_o === 32'hDEADBEEF);
      if (xwb_stb_o === 1'b1 && xwb_we_o === 1'b0 && xwb_adr_o === 30'h200 && i_stb < 0) i_stb = k;
      if (dwb_ack_o === 1'b1 && d_ack < 0) begin
        d_ack = k; d_rd = dwb_dat_o; dwb_stb_i = 1'b0; slv_data = 32'h600DCAFE;
      end
      if (iwb_ack_o === 1'b1 && i_ack < 0) begin
        i_ack = k; i_rd = iwb_dat_o; iwb_stb_i = 1'b0;
      end
    end
    dwb_stb_i = 1'b0; iwb_stb_i = 1'b0;
    model_ddat = 32'h0BADF00D; model_idat = 32'h600DCAFE;
    tests_run++;
    if (!d_ok) begin
      tests_failed++;
      $display("FAIL both_data_grant data request not on xwb in cycle 1 with we=1 sel=3 adr=40 dat=deadbeef");
    end
    tests_run++;
    if (d_ack != 2 || d_rd !== 32'h0BADF00D) begin
      tests_failed++;
      $display("FAIL both_dack cycle=%0d data=%h required cycle=2 data=0badf00d", d_ack, d_rd);
    end
    tests_run++;
    if (i_stb != 4 || i_ack != 5 || i_rd !== 32'h600DCAFE) begin
      tests_failed++;
      $display("FAIL both_iack stb_cycle=%0d ack_cycle=%0d data=%h required 4 5 600dcafe", i_stb, i_ack, i_rd);
    end
    tests_run++;
    if (both != 0) begin
      tests_failed++;
      $display("FAIL both_double_ack cycles_with_two_acks=%0d required 0", both);
    end
  endtask

  task automatic test_wait_states();
    slv_wait = 3; slv_data = 32'h12345678;
    run_xfer(1'b1, 1'b0, 4'hF, 30'h0ABC, 32'h55AA55AA);
    model_ddat = 32'h12345678;
    tests_run++;
    if (obs_ack_cyc != 5 || obs_rd !== 32'h12345678 || obs_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait3_ack cycle=%0d data=%h err=%b required 5 12345678 0", obs_ack_cyc, obs_rd, obs_err);
    end
    tests_run++;
    if (obs_stb_first != 1 || obs_stb_last != 4 || !obs_stable || obs_cyc_mismatch != 0) begin
      tests_failed++;
      $display("FAIL wait3_stable first=%0d last=%0d stable=%0d cyc_mismatch=%0d required 1 4 1 0",
               obs_stb_first, obs_stb_last, obs_stable, obs_cyc_mismatch);
    end
    tests_run++;
    if ({obs_we, obs_sel, obs_adr, obs_wdat} !== {1'b0, 4'hF, 30'h0ABC, 32'h55AA55AA}) begin
      tests_failed++;
      $display("FAIL wait3_fields we=%b sel=%h adr=%h dat=%h", obs_we, obs_sel, obs_adr, obs_wdat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    slv_wait = 1000;
    run_xfer(1'b1, 1'b0, 4'hF, 30'h0300, 32'h0);
    model_ddat = 32'h0;
    tests_run++;
    if (obs_ack_cyc != TOUT + 1 || obs_err !== 1'b1 || obs_rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_ack cycle=%0d err=%b data=%h required %0d 1 0", obs_ack_cyc, obs_err, obs_rd, TOUT + 1);
    end
    tests_run++;
    if (obs_stb_last != TOUT || obs_err_extra != 0 || obs_bad_ack != 0) begin
      tests_failed++;
      $display("FAIL timeout_stb last=%0d extra_err=%0d bad_ack=%0d required %0d 0 0", obs_stb_last, obs_err_extra, obs_bad_ack, TOUT);
    end
    @(posedge clk); #1;
    tests_run++;
    if (fsm_state_o !== IDLE_ENC || bus_err_o !== 1'b0 || dwb_ack_o !== 1'b0 || iwb_dat_o !== model_idat) begin
      tests_failed++;
      $display("FAIL timeout_after state=%0d err=%b ack=%b idat=%h required 0 0 0 %h", fsm_state_o, bus_err_o, dwb_ack_o, iwb_dat_o, model_idat);
    end
  endtask

  task automatic test_stray_ack();
    int acks;
    acks = 0;
    slv_stray = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (iwb_ack_o !== 1'b0 || dwb_ack_o !== 1'b0 || bus_err_o !== 1'b0 || fsm_state_o !== IDLE_ENC) acks++;
    end
    slv_stray = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (acks != 0 || iwb_dat_o !== model_idat || dwb_dat_o !== model_ddat) begin
      tests_failed++;
      $display("FAIL stray_ack bad_cycles=%0d idat=%h ddat=%h required 0 %h %h", acks, iwb_dat_o, dwb_dat_o, model_idat, model_ddat);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    slv_wait = 5; slv_data = 32'h77777777;
    dwb_stb_i = 1'b1; dwb_wre_i = 1'b0; dwb_sel_i = 4'hF; dwb_adr_i = 30'h0555; dwb_dat_i = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (dwb_ack_o !== 1'b0 || iwb_ack_o !== 1'b0) acks++;
      if (k == 2) rst = 1'b1;
    end
    tests_run++;
    if (!outs_zero() || fsm_state_o !== IDLE_ENC) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs state=%0d stb=%b idat=%h ddat=%h required all zero", fsm_state_o, xwb_stb_o, iwb_dat_o, dwb_dat_o);
    end
    rst = 1'b0; dwb_stb_i = 1'b0;
    model_idat = 32'h0; model_ddat = 32'h0;
    for (int k = 4; k <= 8; k++) begin
      @(posedge clk); #1;
      if (dwb_ack_o !== 1'b0 || iwb_ack_o !== 1'b0 || xwb_stb_o !== 1'b0) acks++;
    end
    tests_run++;
    if (acks != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_ack cycles_with_activity=%0d required 0", acks);
    end
    slv_wait = 1; slv_data = 32'hCAFEF00D;
    run_xfer(1'b0, 1'b0, 4'h0, 30'h0420, 32'h0);
    model_idat = 32'hCAFEF00D;
    tests_run++;
    if (obs_ack_cyc != 3 || obs_rd !== 32'hCAFEF00D || obs_err !== 1'b0 || dwb_dat_o !== model_ddat) begin
      tests_failed++;
      $display("FAIL reset_mid_recover cycle=%0d data=%h err=%b ddat=%h required 3 cafef00d 0 0", obs_ack_cyc, obs_rd, obs_err, dwb_dat_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit            is_d;
    logic          we;
    logic [3:0]    sel;
    logic [AW-3:0] adr;
    logic [31:0]   wdat, exp_rd, exp_other, act_other;
    int            w, exp_cyc;
    bit            exp_err;
    for (int n = 0; n < 30; n++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      adr  = 30'($urandom);
      wdat = $urandom;
      w    = $urandom_range(0, 6);
      slv_wait = w; slv_data = $urandom;
      exp_err = (w >= TOUT);
      exp_cyc = 2 + ((w < TOUT - 1) ? w : TOUT - 1);
      exp_q.push_back(exp_err ? 32'h0 : slv_data);
      exp_other = is_d ? model_idat : model_ddat;
      run_xfer(is_d, we, sel, adr, wdat);
      exp_rd = exp_q.pop_front();
      if (is_d) model_ddat = exp_rd; else model_idat = exp_rd;
      act_other = is_d ? iwb_dat_o : dwb_dat_o;
      tests_run++;
      if (obs_ack_cyc != exp_cyc || obs_err !== exp_err || obs_rd !== exp_rd) begin
        tests_failed++;
        $display("FAIL rand_ack n=%0d d=%0d w=%0d cycle=%0d err=%b data=%h required %0d %b %h",
                 n, is_d, w, obs_ack_cyc, obs_err, obs_rd, exp_cyc, exp_err, exp_rd);
      end
      tests_run++;
      if (is_d ? ({obs_we, obs_sel, obs_adr, obs_wdat} !== {we, sel, adr, wdat})
               : ({obs_we, obs_sel, obs_adr, obs_wdat} !== {1'b0, 4'hF, adr, 32'h0})) begin
        tests_failed++;
        $display("FAIL rand_fields n=%0d d=%0d we=%b sel=%h adr=%h dat=%h", n, is_d, obs_we, obs_sel, obs_adr, obs_wdat);
      end
      tests_run++;
      if (obs_stb_first != 1 || obs_stb_last != exp_cyc - 1 || !obs_stable || obs_cyc_mismatch != 0 ||
          obs_bad_ack != 0 || obs_err_extra != 0 || act_other !== exp_other) begin
        tests_failed++;
        $display("FAIL rand_protocol n=%0d first=%0d last=%0d stable=%0d bad_ack=%0d extra_err=%0d other=%h required other=%h",
                 n, obs_stb_first, obs_stb_last, obs_stable, obs_bad_ack, obs_err_extra, act_other, exp_other);
      end
      @(posedge clk); #1;
      tests_run++;
      if (iwb_ack_o !== 1'b0 || dwb_ack_o !== 1'b0 || bus_err_o !== 1'b0 || xwb_stb_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_pulse n=%0d iack=%b dack=%b err=%b stb=%b required all 0", n, iwb_ack_o, dwb_ack_o, bus_err_o, xwb_stb_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifetch_zero_wait();
    test_simultaneous();
    test_wait_states();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aemb_wbmux.md
# aemb_wbmux

Two-master to one-slave Wishbone bus merger placed directly downstream of the AEMB core. It takes the core's instruction port (iwb) and data port (dwb), arbitrates them onto a single external Wishbone master port (xwb), and returns registered data and acknowledges to each core port. It also provides a bus-timeout watchdog, so a missing slave cannot hang the core.

## Interface
- AW, 32: external byte-address width; port addresses carry bits [AW-1:2].
- TOUT, 255: watchdog limit in cycles, range 1..255; counter is 8 bits.
- sys_clk_i  in  1  single clock, rising edge.
- sys_rst_i  in  1  synchronous, active-high reset.
- iwb_stb_i  in  1  instruction request; held until iwb_ack_o.
- iwb_adr_i  in  AW-2  instruction word address.
- iwb_dat_o  out  32  instruction read data, registered.
- iwb_ack_o  out  1  instruction acknowledge, one-cycle pulse.
- dwb_stb_i  in  1  data request; held until dwb_ack_o.
- dwb_wre_i  in  1  data write enable.
- dwb_sel_i  in  4  byte lane selects.
- dwb_adr_i  in  AW-2  data word address.
- dwb_dat_i  in  32  store data.
- dwb_dat_o  out  32  load data, registered.
- dwb_ack_o  out  1  data acknowledge, one-cycle pulse.
- xwb_cyc_o, xwb_stb_o  out  1  external cycle/strobe; always equal.
- xwb_we_o  out  1  external write enable.
- xwb_sel_o  out  4  external byte selects.
- xwb_adr_o  out  AW-2  external word address.
- xwb_dat_o  out  32  external write data.
- xwb_dat_i  in  32  external read data.
- xwb_ack_i  in  1  external acknowledge.
- bus_err_o  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states:
  - IDLE: no request granted; all xwb_* outputs low.
  - IGNT: instruction port owns the bus.
  - DGNT: data port owns the bus.
  - ACK: ack cycle toward the master that owned the bus.
- IDLE transitions:
  - dwb_stb_i=1: go to DGNT. Data has fixed priority because the core stalls fetch while a data access is outstanding.
  - else iwb_stb_i=1: go to IGNT.
  - else stay in IDLE.
- On grant, register the granted port's request onto xwb_* and hold it constant until leaving the grant state.
  - IGNT drives: we=0, sel=4'hF, dat_o=0, adr=iwb_adr_i.
  - DGNT drives: we=dwb_wre_i, sel=dwb_sel_i, dat_o=dwb_dat_i, adr=dwb_adr_i.
- IGNT/DGNT with xwb_ack_i=1:
  - Capture xwb_dat_i into the owning port's dat_o register.
  - Drop xwb_stb_o/xwb_cyc_o.
  - Go to ACK.
- Watchdog:
  - Counter clears on entry to IGNT/DGNT and increments each cycle in the grant state without xwb_ack_i.
  - When the count reaches TOUT-1 with no ack: go to ACK, load 0 into the owning dat_o, assert bus_err_o for exactly the ACK cycle.
  - xwb_ack_i arriving in the expiry cycle wins: normal completion, no error.
- ACK: the owning port's ack_o=1 for exactly this cycle, then IDLE unconditionally. Requests are re-sampled only in IDLE, so a stb_i still high in the ACK cycle is never re-granted.
- A port's dat_o register holds its last value until its next completion.
- The non-owning port's ack_o is never asserted. The non-owning port's stb_i is ignored until IDLE.
- xwb_ack_i in IDLE or ACK is ignored.

## Timing
- Reset, and sys_rst_i at any time including mid-transfer: at the next edge state=IDLE, counter=0. All outputs are 0 (ack, err, xwb_cyc/stb/we, sel, adr, dat, both dat_o). An in-flight external cycle is abandoned.
- Zero-wait slave, with request at cycle 0:
  - Cycle 1: xwb_stb_o=1.
  - xwb_ack_i=1 in cycle 1.
  - Cycle 2: ack_o=1 with data valid.
  - Cycle 3: IDLE.
  - Minimum 3 cycles per transfer, including 1 idle gap.
- N slave wait states give an ack_o at cycle 2+N.
- Timeout: ack_o and bus_err_o fire TOUT+1 cycles after the request cycle.
- Simultaneous iwb and dwb requests: data completes first, then instruction is granted from the IDLE after its ACK.
- xwb_* outputs and all dat_o/ack_o are registered. There are no combinational paths from xwb_* inputs to core-port outputs.

## Test plan
- Reset, then an idle bus for 10 cycles -> every output 0 throughout.
- iwb_stb_i at cycle 0, adr 0x100, zero-wait slave returns 0xB8000010 -> xwb_stb_o high in cycle 1 only with adr 0x100, we=0, sel=F; iwb_ack_o in cycle 2 with iwb_dat_o=0xB8000010.
- Both stb at cycle 0, data write of 0xDEADBEEF to 0x40 with sel=0011, then instruction fetch -> data granted first; dwb_ack_o in cycle 2; instruction xwb_stb_o in cycle 4; iwb_ack_o in cycle 5; never two acks in one cycle.
- Slave with 3 wait states on a data load returning 0x12345678 -> dwb_ack_o in cycle 5 with dwb_dat_o=0x12345678; xwb signals stable cycles 1-4.
- TOUT=4 with a slave that never acks -> dwb_ack_o and bus_err_o in cycle 5, dwb_dat_o=0, xwb_stb_o low from cycle 5, IDLE in cycle 6.
- sys_rst_i asserted in cycle 2 of a 5-wait-state transfer -> outputs 0 from cycle 3; no ack; a new request after reset completes normally.
